// File: rtl/wb_ram_arb_pkg.sv
// Shared definitions for the two-master Wishbone RAM arbiter: state encoding,
// default timeout and a grant decode helper.
package wb_ram_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    localparam int TIMEOUT_CYCLES_DEF = 255;

    typedef logic [1:0] arb_state_t;

    // One-hot view of the active grant, bit N set while master N owns the slave.
    function automatic logic [1:0] grant_onehot(input arb_state_t state);
        return {state == ST_GRANT1, state == ST_GRANT0};
    endfunction

endpackage

// File: rtl/wb_ram_arb_2_if.sv
// Wishbone classic bus bundle with master and slave views; used to group the
// per-port signal sets of wb_ram_arb_2 at instantiation sites.
interface wb_ram_arb_2_if #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    we;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;

    modport master (output adr, dat_w, we, sel, stb, cyc, input dat_r, ack, err);
    modport slave  (input adr, dat_w, we, sel, stb, cyc, output dat_r, ack, err);
endinterface

// File: rtl/wb_rr_arb_2.sv
// Two-way round-robin grant decision: a lone requester wins, a tie goes to the
// master that was not granted last (last = index of the previous winner).
module wb_rr_arb_2 (
    input  logic [1:0] request,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_ram_arb_2.sv
// Two-master Wishbone RAM arbiter. A transfer beat completes when stb (valid) and
// ack (ready) are both high; cyc frames ownership. Build with WB_RAM_ARB_TIMEOUT_EN for the ack timeout.
module wb_ram_arb_2
    import wb_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    input  logic                    m0_we_i,
    input  logic [SELECT_WIDTH-1:0] m0_sel_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_cyc_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    input  logic                    m1_we_i,
    input  logic [SELECT_WIDTH-1:0] m1_sel_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_cyc_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic                    s_we_o,
    output logic [SELECT_WIDTH-1:0] s_sel_o,
    output logic                    s_stb_o,
    output logic                    s_cyc_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    output logic [1:0]              o_state
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_ram_arb_2: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0] r_state;
    logic       r_last;
    logic [1:0] w_req;
    logic [1:0] w_grant;
    logic [1:0] w_gnt;
    logic       w_stb_block;

    assign w_req = {m1_cyc_i, m0_cyc_i};

    wb_rr_arb_2 u_rr (
        .request (w_req),
        .last    (r_last),
        .grant   (w_grant)
    );

    // Reset leaves master 1 as last winner so master 0 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant[0]) begin
                        r_state <= ST_GRANT0;
                        r_last  <= 1'b0;
                    end else if (w_grant[1]) begin
                        r_state <= ST_GRANT1;
                        r_last  <= 1'b1;
                    end
                end
                ST_GRANT0: if (!m0_cyc_i) r_state <= ST_IDLE;
                ST_GRANT1: if (!m1_cyc_i) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_gnt   = grant_onehot(r_state);
    assign o_state = r_state;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        if (w_gnt[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_stb_o = m0_stb_i & ~w_stb_block;
            s_cyc_o = m0_cyc_i;
        end else if (w_gnt[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_stb_o = m1_stb_i & ~w_stb_block;
            s_cyc_o = m1_cyc_i;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & w_gnt[0];
    assign m1_ack_o = s_ack_i & w_gnt[1];

`ifdef WB_RAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_block;
    logic [1:0]       r_err;
    logic             w_stall;
    logic             w_expire;

    assign w_stall  = s_cyc_o & s_stb_o & ~s_ack_i;
    assign w_expire = w_stall && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // After expiry the strobe stays masked until the owner withdraws its own stb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_block  <= 1'b0;
            r_err    <= 2'b00;
        end else begin
            r_err <= w_expire ? w_gnt : 2'b00;
            if (r_state == ST_IDLE || s_ack_i || w_expire) r_to_cnt <= '0;
            else if (w_stall)                              r_to_cnt <= r_to_cnt + 1'b1;
            if (w_expire) r_block <= 1'b1;
            else if (r_state == ST_IDLE || !(|(w_gnt & {m1_stb_i, m0_stb_i}))) r_block <= 1'b0;
        end
    end

    assign w_stb_block = r_block;
    assign m0_err_o    = r_err[0] & w_gnt[0];
    assign m1_err_o    = r_err[1] & w_gnt[1];
`else
    assign w_stb_block = 1'b0;
    assign m0_err_o    = 1'b0;
    assign m1_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ram_arb_2.sv
// Bench for wb_ram_arb_2: directed scenarios then randomized traffic, every cycle
// compared against an ownership-level model of the arbiter.
module tb_wb_ram_arb_2;
    import wb_ram_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    wb_ram_arb_2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) m0_if ();
    wb_ram_arb_2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) m1_if ();
    wb_ram_arb_2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW)) s_if ();

    wb_ram_arb_2 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_if.adr), .m0_dat_i(m0_if.dat_w), .m0_dat_o(m0_if.dat_r),
        .m0_we_i(m0_if.we), .m0_sel_i(m0_if.sel), .m0_stb_i(m0_if.stb), .m0_cyc_i(m0_if.cyc),
        .m0_ack_o(m0_if.ack), .m0_err_o(m0_if.err),
        .m1_adr_i(m1_if.adr), .m1_dat_i(m1_if.dat_w), .m1_dat_o(m1_if.dat_r),
        .m1_we_i(m1_if.we), .m1_sel_i(m1_if.sel), .m1_stb_i(m1_if.stb), .m1_cyc_i(m1_if.cyc),
        .m1_ack_o(m1_if.ack), .m1_err_o(m1_if.err),
        .s_adr_o(s_if.adr), .s_dat_o(s_if.dat_w), .s_we_o(s_if.we), .s_sel_o(s_if.sel),
        .s_stb_o(s_if.stb), .s_cyc_o(s_if.cyc), .s_dat_i(s_if.dat_r), .s_ack_i(s_if.ack),
        .o_state(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the slave, who won last, timeout bookkeeping.
    int       own;
    int       last;
    int       tcnt;
    bit       blk;
    bit [1:0] errf;

    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic mcyc(input int n);
        return (n == 0) ? m0_if.cyc : m1_if.cyc;
    endfunction
    function automatic logic mstb(input int n);
        return (n == 0) ? m0_if.stb : m1_if.stb;
    endfunction
    function automatic logic mwe(input int n);
        return (n == 0) ? m0_if.we : m1_if.we;
    endfunction
    function automatic logic [AW-1:0] madr(input int n);
        return (n == 0) ? m0_if.adr : m1_if.adr;
    endfunction
    function automatic logic [DW-1:0] mdat(input int n);
        return (n == 0) ? m0_if.dat_w : m1_if.dat_w;
    endfunction
    function automatic logic [SW-1:0] msel(input int n);
        return (n == 0) ? m0_if.sel : m1_if.sel;
    endfunction

    task automatic drive(input int n, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        if (n == 0) begin
            m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
            m0_if.adr = adr; m0_if.dat_w = dat; m0_if.sel = sel;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
            m1_if.adr = adr; m1_if.dat_w = dat; m1_if.sel = sel;
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        s_if.ack = 1'b0;
        s_if.dat_r = '0;
    endtask

    task automatic model_reset();
        own = -1; last = 1; tcnt = 0; blk = 1'b0; errf = 2'b00;
    endtask

    task automatic model_update();
        bit [1:0] nerr;
        bit       stall;
        nerr = 2'b00;
        if (!rst_n) begin
            model_reset();
            return;
        end
`ifdef WB_RAM_ARB_TIMEOUT_EN
        stall = (own >= 0) && mcyc(own) && mstb(own) && !blk && !s_if.ack;
        if (own < 0 || !mstb(own)) blk = 1'b0;
        if (own < 0 || s_if.ack) tcnt = 0;
        else if (stall) begin
            tcnt++;
            if (tcnt == TO) begin
                nerr[own] = 1'b1;
                tcnt = 0;
                blk = 1'b1;
            end
        end
`else
        stall = 1'b0;
`endif
        errf = nerr;
        if (own < 0) begin
            if (mcyc(0) && mcyc(1)) own = (last == 1) ? 0 : 1;
            else if (mcyc(0))       own = 0;
            else if (mcyc(1))       own = 1;
            if (own >= 0) last = own;
        end else if (!mcyc(own)) begin
            own = -1;
        end
    endtask

    task automatic check_all();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic          ewe, estb, ecyc;
        ea = '0; ed = '0; es = '0; ewe = 1'b0; estb = 1'b0; ecyc = 1'b0;
        if (own >= 0) begin
            ea = madr(own); ed = mdat(own); es = msel(own); ewe = mwe(own);
            estb = mstb(own) && !blk; ecyc = mcyc(own);
        end
        chk("s_adr", 64'(s_if.adr), 64'(ea));
        chk("s_dat", 64'(s_if.dat_w), 64'(ed));
        chk("s_sel", 64'(s_if.sel), 64'(es));
        chk("s_we", 64'(s_if.we), 64'(ewe));
        chk("s_stb", 64'(s_if.stb), 64'(estb));
        chk("s_cyc", 64'(s_if.cyc), 64'(ecyc));
        chk("m0_ack", 64'(m0_if.ack), 64'(s_if.ack && own == 0));
        chk("m1_ack", 64'(m1_if.ack), 64'(s_if.ack && own == 1));
        chk("m0_err", 64'(m0_if.err), 64'(errf[0] && own == 0));
        chk("m1_err", 64'(m1_if.err), 64'(errf[1] && own == 1));
        chk("m0_dat", 64'(m0_if.dat_r), 64'(s_if.dat_r));
        chk("m1_dat", 64'(m1_if.dat_r), 64'(s_if.dat_r));
        chk("state", 64'(dbg_state), (own < 0) ? 64'd0 : 64'(own + 1));
    endtask

    task automatic tick();
        #1 check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        s_if.err = 1'b0;
        model_reset();
        idle_all();

        // Reset holds everything quiet even with a master requesting.
        drive(0, 1'b1, 1'b1, 1'b1, 16'h1234, 32'h55AA55AA, 4'hF);
        tick();
        tick();
        chk("rst_s_cyc", 64'(s_if.cyc), 64'd0);
        idle_all();
        rst_n = 1'b1;
        tick();

        // Single-master write then read-back through the arbiter.
        drive(0, 1'b1, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        #1 chk("wr_latency_cyc0", 64'(s_if.cyc), 64'd0);
        tick();
        chk("wr_cyc_after_1", 64'(s_if.cyc), 64'd1);
        mem[s_if.adr] = s_if.dat_w;
        s_if.ack = 1'b1;
        #1 chk("wr_ack", 64'(m0_if.ack), 64'd1);
        tick();
        s_if.ack = 1'b0;
        idle_all();
        tick();
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0010, '0, 4'hF);
        tick();
        s_if.dat_r = mem.exists(s_if.adr) ? mem[s_if.adr] : '0;
        s_if.ack = 1'b1;
        #1 chk("rd_data", 64'(m0_if.dat_r), 64'hDEADBEEF);
        chk("rd_ack", 64'(m0_if.ack), 64'd1);
        tick();
        idle_all();
        tick();

        // Tie straight after reset goes to master 0, then master 1, then master 0.
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0100, '0, 4'h1);
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0200, '0, 4'h2);
        tick();
        chk("tie_first_m0", 64'(dbg_state), 64'(ST_GRANT0));
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("tie_gap_idle", 64'(dbg_state), 64'(ST_IDLE));
        tick();
        chk("tie_then_m1", 64'(dbg_state), 64'(ST_GRANT1));
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0300, '0, 4'h4);
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0400, '0, 4'h8);
        tick();
        chk("tie_second_m0", 64'(dbg_state), 64'(ST_GRANT0));
        idle_all();
        tick();
        tick();

        // No preemption: master 1 holds the bus for 8 cycles with master 0 waiting.
        drive(1, 1'b1, 1'b1, 1'b1, 16'h0020, 32'h01234567, 4'hF);
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0030, '0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            s_if.ack = 1'($urandom_range(0, 1));
            tick();
            chk("hold_m0_ack", 64'(m0_if.ack), 64'd0);
            chk("hold_state", 64'(dbg_state), 64'(ST_GRANT1));
        end
        s_if.ack = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        chk("hold_then_m0", 64'(dbg_state), 64'(ST_GRANT0));
        idle_all();
        tick();
        tick();

        // Asynchronous reset in the middle of a granted write.
        drive(0, 1'b1, 1'b1, 1'b1, 16'h0040, 32'hCAFEF00D, 4'hF);
        tick();
        s_if.ack = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("arst_s_cyc", 64'(s_if.cyc), 64'd0);
        chk("arst_s_stb", 64'(s_if.stb), 64'd0);
        chk("arst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("arst_m0_ack", 64'(m0_if.ack), 64'd0);
        @(posedge clk);
        #1;
        idle_all();
        tick();
        rst_n = 1'b1;
        tick();

`ifdef WB_RAM_ARB_TIMEOUT_EN
        // Slave never acks: error pulse after TO stalled cycles, strobe masked.
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0050, '0, 4'hF);
        tick();
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0060, '0, 4'hF);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("to_no_err_early", 64'(m0_if.err), 64'd0);
        end
        tick();
        chk("to_err_pulse", 64'(m0_if.err), 64'd1);
        chk("to_stb_forced", 64'(s_if.stb), 64'd0);
        chk("to_m1_err", 64'(m1_if.err), 64'd0);
        tick();
        chk("to_err_one_cycle", 64'(m0_if.err), 64'd0);
        chk("to_stb_still_low", 64'(s_if.stb), 64'd0);
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0050, '0, 4'hF);
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 16'h0050, '0, 4'hF);
        #1 chk("to_stb_released", 64'(s_if.stb), 64'd1);
        s_if.ack = 1'b1;
        tick();
        idle_all();
        tick();
        tick();
`endif

        // Randomized traffic against the model, with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                logic c;
                c = mcyc(n);
                if ($urandom_range(0, 3) == 0) c = ~c;
                drive(n, c, c ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)),
                      AW'($urandom), DW'($urandom), SW'($urandom));
            end
            s_if.ack = ($urandom_range(0, 2) == 0);
            s_if.dat_r = DW'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        idle_all();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_ram_arb_2.md
WB_RAM_ARB_2 -- requirements
Module: wb_ram_arb_2

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the byte address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width of all ports (8/16/32/64).
REQ-003 Parameter SELECT_WIDTH, default DATA_WIDTH/8, SHALL set the byte-select width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, SHALL set the cycles waited for slave ack before error (timeout build only).
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-006 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 mN_adr_i  input  ADDR_WIDTH  master N address (N = 0, 1).
REQ-009 mN_dat_i  input  DATA_WIDTH  master N write data.
REQ-010 mN_dat_o  output  DATA_WIDTH  master N read data.
REQ-011 mN_we_i / mN_sel_i / mN_stb_i / mN_cyc_i  input  1 / SELECT_WIDTH / 1 / 1  master N write enable, select, strobe, cycle.
REQ-012 mN_ack_o / mN_err_o  output  1 / 1  master N acknowledge, error.
REQ-013 s_adr_o / s_dat_o / s_we_o / s_sel_o / s_stb_o / s_cyc_o  output  ADDR_WIDTH / DATA_WIDTH / 1 / SELECT_WIDTH / 1 / 1  RAM-side bus.
REQ-014 s_dat_i / s_ack_i  input  DATA_WIDTH / 1  RAM-side read data, acknowledge.

Function
REQ-015 The block SHALL share one Wishbone RAM slave between two masters, with states IDLE, GRANT0 and GRANT1.
REQ-016 In IDLE, if exactly one mN_cyc_i is high, the next state SHALL be GRANTN.
REQ-017 In IDLE with both mN_cyc_i high, the grant SHALL go to the master not granted last (round-robin).
REQ-018 Grant SHALL be registered, giving one cycle of arbitration latency from mN_cyc_i rising to s_cyc_o rising.
REQ-019 In GRANTN, the state SHALL hold while mN_cyc_i is high and SHALL return to IDLE in the cycle after mN_cyc_i falls.
REQ-020 A request from the other master SHALL NOT preempt an active grant.
REQ-021 s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o and s_cyc_o SHALL be combinational copies of the granted master's inputs, and all zero in IDLE.
REQ-022 mN_dat_o SHALL equal s_dat_i; mN_ack_o SHALL equal s_ack_i gated by GRANTN, with no added latency.
REQ-023 The non-granted master SHALL see ack_o = 0 and err_o = 0 at all times.
REQ-024 The last-granted record SHALL update on every entry to GRANT0/GRANT1.

Reset
REQ-025 While rst_n is low: state = IDLE, last-granted = master 1 (master 0 wins the first tie), all s_* outputs 0, all mN_ack_o/mN_err_o 0.
REQ-026 Reset asserted mid-cycle SHALL drop s_cyc_o and s_stb_o immediately (asynchronously).
REQ-027 After reset release, arbitration SHALL resume on the first clk edge.

Configuration
REQ-028 With macro WB_RAM_ARB_TIMEOUT_EN defined, a counter SHALL increment each cycle that s_cyc_o & s_stb_o & ~s_ack_i holds, and clear on ack or in IDLE.
REQ-029 When that counter reaches TIMEOUT_CYCLES, the block SHALL pulse the granted mN_err_o for one cycle and SHALL force s_stb_o low until the master drops mN_stb_i.
REQ-030 Without WB_RAM_ARB_TIMEOUT_EN, there SHALL be no counter logic and mN_err_o SHALL be constant 0.

Structure
REQ-031 A shared package wb_ram_arb_pkg SHALL hold the state encoding (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2) and the default TIMEOUT_CYCLES constant.
REQ-032 The round-robin grant decision SHALL be a sub-module, wb_rr_arb_2 (inputs: request[1:0], last; output: grant[1:0]).
REQ-033 The timeout counter SHALL stay in the top level.

Verification
REQ-034 m0 write: adr 0x0010, dat 0xDEADBEEF, sel 4'hF, m1 idle -> s_cyc_o high one cycle after m0_cyc_i; m0_ack_o on the RAM ack; a later m0 read of 0x0010 returns 0xDEADBEEF.
REQ-035 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; after m0 drops cyc, m1 granted on the next-but-one edge; the next tie goes to m0.
REQ-036 m1 granted holding cyc for 8 cycles with m0 requesting -> m0_ack_o stays 0 throughout; m0 is granted only after m1_cyc_i falls.
REQ-037 rst_n driven low during a granted m0 write -> s_cyc_o falls without waiting for a clock; state IDLE; m0_ack_o 0.
REQ-038 Timeout build, TIMEOUT_CYCLES=4, slave ack held low -> m0_err_o pulses one cycle after 4 unacked strobe cycles; s_stb_o forced low; m1 unaffected.
REQ-039 Non-timeout build -> m0_err_o and m1_err_o remain 0 under all stimuli.
